vgachargen_pattern_gen: RTL and testbench
=========================================

VGACHARGEN_PATTERN_GEN -- requirements
Module: vgachargen_pattern_gen

Interface
REQ-001 SHALL have parameter NUM_COLS, default 80: text columns.
REQ-002 SHALL have parameter NUM_ROWS, default 30: text rows.
REQ-003 SHALL have parameter SCROLL_PERIOD, default 25_000_000: idle cycles between refills in scroll mode; must be >= 1.
REQ-004 SHALL have parameter COLOR_CODE, default 8'h0F: colour byte written for every character.
REQ-005 SHALL have localparam WORDS = NUM_COLS*NUM_ROWS/4 (product must be a multiple of 4), and ADDR_W = $clog2(WORDS).
REQ-006 SHALL have port clk_i, input, 1: the single clock.
REQ-007 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port start_i, input, 1: begin fill; sampled only in IDLE.
REQ-009 SHALL have port scroll_i, input, 1: 0 = single fill, 1 = continuous scroll; sampled with start_i.
REQ-010 SHALL have port stop_i, input, 1: leave scroll mode.
REQ-011 SHALL have port busy_o, output, 1: high whenever the FSM is not in IDLE.
REQ-012 SHALL have port done_o, output, 1: one-cycle pulse at the end of each fill.
REQ-013 SHALL have port char_map_addr_o/ce_o/we_o/be_o/wdata_o, output, ADDR_W/1/1/4/32: char map write port.
REQ-014 SHALL have port col_map_addr_o/ce_o/we_o/be_o/wdata_o, output, ADDR_W/1/1/4/32: colour map write port.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, WAIT.
REQ-016 IDLE->FILL SHALL occur on start_i=1; the mode is latched at that edge and the word address is set to 0.
REQ-017 FILL SHALL write one word per cycle to both maps at the same address, addresses 0..WORDS-1 ascending, with ce=we=1 and be=4'hF.
REQ-018 All write-port outputs SHALL be registered; start_i at edge N gives the first write (addr 0) visible after edge N+1.
REQ-019 Byte k of word w SHALL carry character index i=4w+k, with char = 8'h20 + ((i+offset) mod 95) (printable ASCII 0x20..0x7E).
REQ-020 Every colour byte SHALL equal COLOR_CODE.
REQ-021 After the write to WORDS-1: ce/we SHALL drop, and done_o SHALL pulse for exactly one cycle.
REQ-022 After that last write, the FSM SHALL go to WAIT if scroll mode is latched and stop is not pending; otherwise it goes to IDLE.
REQ-023 WAIT SHALL count SCROLL_PERIOD cycles, then set offset=(offset+1) mod 95 (94 wraps to 0), then return to FILL at addr 0.
REQ-024 stop_i during FILL SHALL set a stop-pending flag; the current fill completes, then the FSM goes to IDLE.
REQ-025 stop_i during WAIT SHALL send the FSM to IDLE on the next edge without a refill.
REQ-026 start_i outside IDLE SHALL be ignored.
REQ-027 Offset SHALL persist across IDLE; single-fill mode never changes it.
REQ-028 When ce_o=0, wdata_o and addr_o are don't-care.

Reset
REQ-029 rst_i=1 SHALL asynchronously force: state IDLE, addresses 0, offset 0, wait counter 0, stop-pending 0, all ce/we/be 0, done_o 0, busy_o 0.
REQ-030 Reset mid-FILL or mid-WAIT SHALL abort with no further writes; the next start_i begins at addr 0 with offset 0.

Structure
REQ-031 The state enum and the constants 8'h20, 95 and 4'hF SHALL live in a shared package vgachargen_pkg.
REQ-032 Character generation SHALL use wrapping running counters, not division; the pattern is produced by one sub-module, vgachargen_ascii_ctr (4 parallel wrapping byte counters).
REQ-033 Target size SHALL be 150-300 lines; vgachargen_synth may instantiate this block in place of its tied-off write ports.

Verification
REQ-034 Bench SHALL use NUM_COLS=8, NUM_ROWS=2, SCROLL_PERIOD=3, giving WORDS=4.
REQ-035 Single fill: start_i=1, scroll_i=0 -> 4 writes at addr 0..3; word0 wdata=32'h23222120 (byte0 lowest); col wdata=32'h0F0F0F0F; done_o pulses once; then IDLE.
REQ-036 Scroll: start_i=1, scroll_i=1 -> after fill #1, exactly 3 WAIT cycles, then fill #2 with word0=32'h24232221.
REQ-037 Wrap: run 95 scroll fills -> fill #96 word0 equals fill #1 (32'h23222120); char code 0x7E is followed by 0x20 within a word.
REQ-038 Stop: stop_i during fill #2 -> fill #2 completes (4 writes), done_o pulses, FSM enters IDLE, no WAIT; a subsequent start_i is accepted.
REQ-039 Reset: rst_i asserted at the write to addr 2 -> ce/we drop immediately, busy_o=0; a re-start yields word0=32'h23222120.

Source files
------------

// File: rtl/vgachargen_pkg.sv
// Shared definitions for the VGA character-map pattern generator.
//   state_t     : controller states (idle / filling / waiting between scrolls)
//   CHAR_BASE   : first printable ASCII code (space)
//   CHAR_SPAN   : number of printable codes (0x20..0x7E)
//   CHAR_LAST   : last printable ASCII code (tilde)
//   BE_ALL      : byte enable for full-word writes
package vgachargen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] CHAR_BASE = 8'h20;
    localparam logic [7:0] CHAR_SPAN = 8'd95;
    localparam logic [7:0] CHAR_LAST = 8'h7E;
    localparam logic [3:0] BE_ALL    = 4'hF;

endpackage

// File: rtl/vgachargen_ascii_ctr.sv
// Four parallel wrapping byte counters producing one 32-bit word of
// printable ASCII per step. Byte k holds 0x20 + ((4w + k + offset) mod 95).
//   clk_i     : clock
//   load_i    : reload counters for word 0 using base_i as the offset
//   advance_i : step every byte forward by 4 characters (next word)
//   base_i    : scroll offset, 0..94
//   word_o    : current word, byte 0 in bits [7:0]
module vgachargen_ascii_ctr
    import vgachargen_pkg::*;
(
    input  logic        clk_i,
    input  logic        load_i,
    input  logic        advance_i,
    input  logic [6:0]  base_i,
    output logic [31:0] word_o
);

    logic [3:0][7:0] chars;

    // Add a small step to a printable code, wrapping 0x7E back to 0x20.
    // Step is always < 95, so one conditional subtract is enough.
    function automatic logic [7:0] wrap_char(input logic [7:0] c, input logic [7:0] step);
        logic [8:0] s;
        s = {1'b0, c} + {1'b0, step};
        if (s > {1'b0, CHAR_LAST}) begin
            s = s - {1'b0, CHAR_SPAN};
        end
        return s[7:0];
    endfunction

    // Counters hold data only; they are always reloaded before use.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (load_i) begin
                chars[k] <= wrap_char(CHAR_BASE + {1'b0, base_i}, 8'(k));
            end else if (advance_i) begin
                chars[k] <= wrap_char(chars[k], 8'd4);
            end
        end
    end

    assign word_o = chars;

endmodule

// File: rtl/vgachargen_pattern_gen.sv
// Fills the character and colour maps of the text display with a repeating
// printable-ASCII pattern, either once or continuously with a scroll offset
// that advances by one character after each idle period.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   start_i, scroll_i   : begin a fill; scroll_i selects continuous mode
//   stop_i              : leave scroll mode (after the current fill)
//   busy_o, done_o      : not idle; one-cycle pulse after each fill
//   char_map_*          : character map write port (registered)
//   col_map_*           : colour map write port (registered, same timing)
module vgachargen_pattern_gen
    import vgachargen_pkg::*;
#(
    parameter  int         NUM_COLS      = 80,
    parameter  int         NUM_ROWS      = 30,
    parameter  int         SCROLL_PERIOD = 25_000_000,
    parameter  logic [7:0] COLOR_CODE    = 8'h0F,
    localparam int         WORDS         = NUM_COLS * NUM_ROWS / 4,
    localparam int         ADDR_W        = $clog2(WORDS)
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              scroll_i,
    input  logic              stop_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] char_map_addr_o,
    output logic              char_map_ce_o,
    output logic              char_map_we_o,
    output logic [3:0]        char_map_be_o,
    output logic [31:0]       char_map_wdata_o,
    output logic [ADDR_W-1:0] col_map_addr_o,
    output logic              col_map_ce_o,
    output logic              col_map_we_o,
    output logic [3:0]        col_map_be_o,
    output logic [31:0]       col_map_wdata_o
);

    localparam int WAIT_W = (SCROLL_PERIOD > 1) ? $clog2(SCROLL_PERIOD) : 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [6:0]        offset, offset_inc, load_base;
    logic              scroll_mode, stop_pend, last_wr;
    logic              fill_last, wait_done, ctr_load;
    logic [31:0]       pattern;
    logic              wr_en;
    logic [3:0]        wr_be;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       char_data, col_data;

    assign fill_last  = (addr_cnt == ADDR_W'(WORDS - 1));
    assign wait_done  = (wait_cnt == WAIT_W'(SCROLL_PERIOD - 1));
    assign offset_inc = (offset == 7'(CHAR_SPAN - 8'd1)) ? 7'd0 : offset + 7'd1;
    // A refill out of WAIT already uses the advanced offset.
    assign load_base  = (state == ST_WAIT) ? offset_inc : offset;

    always_comb begin
        state_nxt = state;
        ctr_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = ST_FILL;
                    ctr_load  = 1'b1;
                end
            end
            ST_FILL: begin
                if (fill_last) begin
                    // stop_i on the final fill cycle counts as pending too.
                    state_nxt = (scroll_mode && !stop_pend && !stop_i) ? ST_WAIT : ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (stop_i) begin
                    state_nxt = ST_IDLE;
                end else if (wait_done) begin
                    state_nxt = ST_FILL;
                    ctr_load  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Control: counters, mode, offset, done and write strobes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_cnt    <= '0;
            wait_cnt    <= '0;
            offset      <= '0;
            scroll_mode <= 1'b0;
            stop_pend   <= 1'b0;
            last_wr     <= 1'b0;
            done_o      <= 1'b0;
            wr_en       <= 1'b0;
            wr_be       <= '0;
            wr_addr     <= '0;
        end else begin
            last_wr <= (state == ST_FILL) && fill_last;
            done_o  <= last_wr;
            wr_en   <= (state == ST_FILL);
            wr_be   <= (state == ST_FILL) ? BE_ALL : 4'h0;
            wr_addr <= addr_cnt;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        addr_cnt    <= '0;
                        wait_cnt    <= '0;
                        scroll_mode <= scroll_i;
                        stop_pend   <= 1'b0;
                    end
                end
                ST_FILL: begin
                    addr_cnt <= fill_last ? '0 : addr_cnt + ADDR_W'(1);
                    if (stop_i) begin
                        stop_pend <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (stop_i) begin
                        wait_cnt <= '0;
                    end else if (wait_done) begin
                        wait_cnt <= '0;
                        offset   <= offset_inc;
                        addr_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Data: write words, don't-care while the strobes are low
    always_ff @(posedge clk_i) begin
        char_data <= pattern;
        col_data  <= {4{COLOR_CODE}};
    end

    vgachargen_ascii_ctr u_ascii_ctr (
        .clk_i     (clk_i),
        .load_i    (ctr_load),
        .advance_i (state == ST_FILL),
        .base_i    (load_base),
        .word_o    (pattern)
    );

    assign busy_o           = (state != ST_IDLE);
    assign char_map_addr_o  = wr_addr;
    assign char_map_ce_o    = wr_en;
    assign char_map_we_o    = wr_en;
    assign char_map_be_o    = wr_be;
    assign char_map_wdata_o = char_data;
    assign col_map_addr_o   = wr_addr;
    assign col_map_ce_o     = wr_en;
    assign col_map_we_o     = wr_en;
    assign col_map_be_o     = wr_be;
    assign col_map_wdata_o  = col_data;

endmodule

// File: tb/tb_vgachargen_pattern_gen.sv
// Scoreboard bench for vgachargen_pattern_gen with an 8x2 map (4 words).
module tb_vgachargen_pattern_gen;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1, start_i = 1'b0, scroll_i = 1'b0, stop_i = 1'b0;
    logic          busy_o, done_o;
    logic [AW-1:0] char_map_addr_o, col_map_addr_o;
    logic          char_map_ce_o, char_map_we_o, col_map_ce_o, col_map_we_o;
    logic [3:0]    char_map_be_o, col_map_be_o;
    logic [31:0]   char_map_wdata_o, col_map_wdata_o;

    always #5 clk = ~clk;

    vgachargen_pattern_gen #(
        .NUM_COLS(8), .NUM_ROWS(2), .SCROLL_PERIOD(3), .COLOR_CODE(8'h0F)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .scroll_i(scroll_i), .stop_i(stop_i),
        .busy_o(busy_o), .done_o(done_o),
        .char_map_addr_o(char_map_addr_o), .char_map_ce_o(char_map_ce_o),
        .char_map_we_o(char_map_we_o), .char_map_be_o(char_map_be_o),
        .char_map_wdata_o(char_map_wdata_o),
        .col_map_addr_o(col_map_addr_o), .col_map_ce_o(col_map_ce_o),
        .col_map_we_o(col_map_we_o), .col_map_be_o(col_map_be_o),
        .col_map_wdata_o(col_map_wdata_o)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   cdata;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] w0_q[$];
    int          gap_q[$];
    int          checks = 0, errors = 0;
    int          done_cnt = 0, gap = 0;
    logic        prev_ce = 1'b0, prev_done = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference pattern: byte k of word w = 0x20 + ((4w+k+off) mod 95).
    function automatic logic [31:0] model_word(input int off, input int w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = 8'(32 + ((4*w + k + off) % 95));
        return r;
    endfunction

    task automatic push_fill(input int off, input int nwords);
        wr_t e;
        for (int w = 0; w < nwords; w++) begin
            e.addr  = AW'(w);
            e.cdata = model_word(off, w);
            exp_q.push_back(e);
        end
    endtask

    task automatic start(input logic s);
        @(negedge clk);
        start_i  = 1'b1;
        scroll_i = s;
        @(negedge clk);
        start_i  = 1'b0;
        scroll_i = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL wait_done: done count %0d, expected %0d within %0d cycles", done_cnt, target, budget);
        end
    endtask

    // Monitor: compares every presented write against the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (char_map_ce_o) begin
            if (!prev_ce) begin
                gap_q.push_back(gap);
                gap = 0;
            end
            if (char_map_addr_o == '0) w0_q.push_back(char_map_wdata_o);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %h, no write expected", char_map_addr_o, char_map_wdata_o);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(char_map_addr_o), 32'(e.addr));
                check("char_wdata", char_map_wdata_o, e.cdata);
                check("col_wdata", col_map_wdata_o, 32'h0F0F0F0F);
                check("strobes", {char_map_we_o, col_map_ce_o, col_map_we_o, char_map_be_o, col_map_be_o},
                      {3'b111, 4'hF, 4'hF});
                check("col_addr", 32'(col_map_addr_o), 32'(e.addr));
            end
        end else begin
            gap++;
        end
        if (done_o) begin
            done_cnt++;
            check("done_after_last", {prev_ce, prev_addr == 2'd3, char_map_ce_o}, 3'b110);
            check("done_width", 32'(prev_done), 32'd0);
        end
        prev_ce   = char_map_ce_o;
        prev_addr = char_map_addr_o;
        prev_done = done_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_ce_we", {char_map_ce_o, char_map_we_o, col_map_ce_o, col_map_we_o}, 4'b0000);
        check("reset_be", {char_map_be_o, col_map_be_o}, 8'h00);
        check("reset_busy_done", {busy_o, done_o}, 2'b00);
        rst_i = 1'b0;

        // Single fill
        w0_q.delete();
        push_fill(0, 4);
        start(1'b0);
        wait_done(1, 30);
        repeat (4) @(negedge clk);
        check("single_busy", 32'(busy_o), 32'd0);
        check("single_done_count", done_cnt, 1);
        check("single_word0", w0_q[0], 32'h23222120);
        check("single_queue_empty", exp_q.size(), 0);

        // Scroll through 96 fills; start_i during FILL must be ignored
        w0_q.delete();
        gap_q.delete();
        for (int f = 0; f < 96; f++) push_fill(f, 4);
        start(1'b1);
        start_i = 1'b1;
        scroll_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(97, 2000);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        repeat (6) @(negedge clk);
        check("scroll_busy_after_stop", 32'(busy_o), 32'd0);
        check("scroll_queue_empty", exp_q.size(), 0);
        check("scroll_fill1_word0", w0_q[0], 32'h23222120);
        check("scroll_fill2_word0", w0_q[1], 32'h24232221);
        check("scroll_fill95_wrap", w0_q[94], 32'h2221207E);
        check("scroll_fill96_word0", w0_q[95], 32'h23222120);
        check("scroll_gap_1_2", gap_q[1], 3);
        check("scroll_gap_95_96", gap_q[95], 3);

        // Stop during fill #2: it completes, then IDLE without WAIT
        push_fill(0, 4);
        push_fill(1, 4);
        start(1'b1);
        wait_done(98, 30);
        n = 0;
        while (!char_map_ce_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stop_fill2_started", 32'(char_map_ce_o), 32'd1);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        wait_done(99, 20);
        repeat (6) @(negedge clk);
        check("stop_busy", 32'(busy_o), 32'd0);
        check("stop_done_count", done_cnt, 99);
        check("stop_queue_empty", exp_q.size(), 0);

        // Restart after stop: offset 1 persists through IDLE
        w0_q.delete();
        push_fill(1, 4);
        start(1'b0);
        wait_done(100, 30);
        repeat (3) @(negedge clk);
        check("restart_word0", w0_q[0], 32'h24232221);

        // Reset at the write to addr 2, then re-start from offset 0
        push_fill(1, 3);
        start(1'b1);
        n = 0;
        while (!(char_map_ce_o && char_map_addr_o == 2'd2) && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1 rst_i = 1'b1;
        #1;
        check("rst_mid_strobes", {char_map_ce_o, char_map_we_o, col_map_ce_o, char_map_be_o}, 7'b0);
        check("rst_mid_busy_done", {busy_o, done_o}, 2'b00);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_queue_empty", exp_q.size(), 0);
        w0_q.delete();
        push_fill(0, 4);
        start(1'b0);
        wait_done(101, 30);
        repeat (3) @(negedge clk);
        check("rst_restart_word0", w0_q[0], 32'h23222120);
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
